muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//
// Multiplies use radix-2 shift-add over a 64-bit product. Divides use
// restoring division and produce one quotient bit per cycle. Both work on
// operand magnitudes, and the sign is applied when the result is loaded.
// Divide-by-zero and signed overflow finish in one cycle.
//
// Optional feature (define MULDIV_FAST_MUL_EN): the four multiply ops use a
// single-cycle combinational multiply and go straight from IDLE to DONE.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request, sampled only in IDLE
//   op            M-extension funct3
//   src1, src2    operands, captured when start is accepted
//   flush         aborts any operation, wins over start
//   busy          unit occupied (CALC or DONE)
//   done          one-cycle pulse, result valid
//   result        registered result, held until the next result load
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    // Captured request: the opcode, plus the sign to apply to the selected result.
    typedef struct packed {
        logic [2:0] op;
        logic       neg;
    } ctl_t;

    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    ctl_t              ctl_q, ctl_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product, or {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step;
    logic [XLEN:0]     div_sh;
    logic [XLEN-1:0]   div_sub;
    logic              div_ge;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    // Applies the sign to the magnitude result and selects the output word.
    function automatic logic [XLEN-1:0] fin(input logic [2:0] o, input logic n,
                                            input logic [2*XLEN-1:0] a);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = n ? -a : a;
        q = n ? -a[XLEN-1:0] : a[XLEN-1:0];
        r = n ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        if (o[2])                fin = o[1] ? r : q;
        else if (o[1:0] == 2'b00) fin = p[XLEN-1:0];
        else                     fin = p[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        state_d  = state_q;
        ctl_d    = ctl_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // Signedness from funct3. MULHU and the unsigned divides are unsigned;
        // MULHSU has a signed src1 only.
        is_div = op[2];
        s1     = src1[XLEN-1] & (is_div ? ~op[0] : (op[1:0] != 2'b11));
        s2     = src2[XLEN-1] & (is_div ? ~op[0] : ~op[1]);
        mag1   = s1 ? -src1 : src1;
        mag2   = s2 ? -src2 : src2;

        // Shift-add step. The low half holds the remaining multiplier bits.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring step. The partial remainder always stays below the divisor,
        // so the modular 32-bit subtract is exact whenever it is taken.
        div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge  = div_sh >= {1'b0, opnd_q};
        div_sub = div_sh[XLEN-1:0] - opnd_q;
        div_nxt = {(div_ge ? div_sub : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        step = ctl_q.op[2] ? div_nxt : mul_nxt;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctl_d.op  = op;
                    // The remainder takes the dividend's sign.
                    ctl_d.neg = (is_div && op[1]) ? s1 : (s1 ^ s2);
                    cnt_d     = '0;
                    if (is_div && src2 == '0) begin
                        result_d = op[1] ? src1 : '1;
                        state_d  = S_DONE;
                    end else if (is_div && !op[0] && src1 == INT_MIN && src2 == '1) begin
                        result_d = op[1] ? '0 : INT_MIN;
                        state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        result_d = fin(op, s1 ^ s2, fast_prod);
                        state_d  = S_DONE;
`endif
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                        opnd_d  = is_div ? mag2 : mag1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_END) begin
                    result_d = fin(ctl_q.op, ctl_q.neg, step);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the operation without touching the visible result.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ctl_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
